load_store_unit: RTL and testbench

// Sits between the MEM pipeline stage and data_memory. Turns RV32I loads/stores
// (LB/LH/LW/LBU/LHU, SB/SH/SW) into word-only data_memory accesses. Handles

---
 rtl/load_store_unit.sv | 102 ++++++++++
 tb/tb_load_store_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I loads/stores mapped onto word-only data_memory accesses
module load_store_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);
    typedef enum logic [2:0] {IDLE, LD_RD, LD_CAP, ST_RD, ST_CAP, ST_WR, DONE} state_t;
    state_t      state_q, state_d;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic [31:0] addr_q, rdata_q, wout_q;
    logic        err_q;
    logic        accept, f3_bad, misalign, oor, req_err;
    logic [4:0]  sh;
    logic [31:0] rd_shift, ld_val, st_val;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sx;
    assign accept   = (state_q == IDLE) && req_valid;
    assign f3_bad   = req_write ? (req_funct3[2] || req_funct3 == 3'b011)
                                : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    assign misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                      (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    assign oor      = req_addr >= 32'(MEM_WORDS * 4);
    assign req_err  = f3_bad || misalign || oor;
    assign sh       = {lane_q, 3'b000};
    assign rd_shift = mem_read_data >> sh;
    assign byte_v   = rd_shift[7:0];
    assign half_v   = lane_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    assign sx       = ~funct3_q[2];
    assign ld_val   = funct3_q[1:0] == 2'b00 ? {{24{sx & byte_v[7]}}, byte_v} :
                      funct3_q[1:0] == 2'b01 ? {{16{sx & half_v[15]}}, half_v} : mem_read_data;
    // Sub-word store merge keeps every byte outside the addressed lanes untouched
    assign st_val   = funct3_q[0] ? (lane_q[1] ? {wdata_q, mem_read_data[15:0]}
                                               : {mem_read_data[31:16], wdata_q})
                                  : (mem_read_data & ~(32'h0000_00FF << sh)) |
                                    ({24'b0, wdata_q[7:0]} << sh);
    assign busy           = state_q != IDLE;
    assign resp_valid     = state_q == DONE;
    assign resp_rdata     = rdata_q;
    assign resp_error     = err_q;
    assign mem_read       = (state_q == LD_RD) || (state_q == ST_RD);
    assign mem_write      = (state_q == ST_WR) && !reset;
    assign mem_address    = addr_q;
    assign mem_write_data = wout_q;
    // Next-state: errors skip memory, SW writes directly, SB/SH read first
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_err ? DONE : !req_write ? LD_RD :
                                              req_funct3[1] ? ST_WR : ST_RD;
            LD_RD:   state_d = LD_CAP;
            LD_CAP:  state_d = DONE;
            ST_RD:   state_d = ST_CAP;
            ST_CAP:  state_d = ST_WR;
            ST_WR:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    // State register plus request latch, load result capture and write-word build
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            funct3_q <= '0;
            lane_q   <= '0;
            wdata_q  <= '0;
            addr_q   <= '0;
            rdata_q  <= '0;
            wout_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                funct3_q <= req_funct3;
                lane_q   <= req_addr[1:0];
                wdata_q  <= req_wdata[15:0];
                addr_q   <= {req_addr[31:2], 2'b00};
                wout_q   <= req_wdata;
                rdata_q  <= '0;
                err_q    <= req_err;
            end
            if (state_q == LD_CAP) rdata_q <= ld_val;
            if (state_q == ST_CAP) wout_q <= st_val;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with byte-array reference model
module tb_load_store_unit;
    logic        clk = 0, reset = 1, req_valid = 0, req_write = 0;
    logic [2:0]  req_funct3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
    logic        busy, resp_valid, resp_error, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_address, mem_write_data;

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          rd;
        int          wr;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        e_m;
    logic [31:0] dmem [0:1023];
    logic [7:0]  refb [0:4095];
    int          cyc = 0, checks = 0, failures = 0;
    int          rd_cnt = 0, wr_cnt = 0, resp_cnt = 0;
    logic [31:0] last_rdata = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Word-wide data memory: read data appears the cycle after mem_read
    always @(posedge clk) begin
        if (mem_write) dmem[mem_address[11:2]] <= mem_write_data;
        if (mem_read) mem_rdata <= dmem[mem_address[11:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setword(input int idx, input logic [31:0] v);
        dmem[idx] <= v;
        for (int i = 0; i < 4; i++) refb[idx*4+i] = v[8*i +: 8];
    endtask

    // Reference: byte-addressed memory and RV32I access rules
    task automatic predict(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output exp_t e);
        int n;
        logic bad;
        logic [31:0] v;
        n = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
        bad = (w ? f3 > 3'd2 : (f3 == 3'd3 || f3 > 3'd5)) || (a % n != 0) || a >= 32'd4096;
        e = '{err: bad, rdata: 0, lat: 1, rd: 0, wr: 0, acc: 0};
        if (!bad && !w) begin
            v = 0;
            for (int i = 0; i < n; i++) v |= 32'(refb[a+i]) << (8*i);
            if (!f3[2] && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8*n);
            e.rdata = v;
            e.lat = 3;
            e.rd = 1;
        end else if (!bad) begin
            for (int i = 0; i < n; i++) refb[a+i] = wd[8*i +: 8];
            e.wr = 1;
            e.lat = n == 4 ? 2 : 4;
            e.rd = n == 4 ? 0 : 1;
        end
    endtask

    // Present a request (req_valid left high) until the DUT accepts it
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit push);
        exp_t e;
        int t = 0;
        req_valid = 1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        while (busy) begin
            @(negedge clk);
            if (++t > 50) begin
                failures++;
                $display("FAIL accept_timeout: busy stuck high after %0d cycles", t);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
        if (push) begin
            predict(w, f3, a, wd, e);
            e.acc = cyc;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        req_valid = 0;
        while ((q.size() != 0 || busy) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 32'(q.size()), 0);
    endtask

    // Monitor: pops the scoreboard on every response and checks data, latency, memory traffic
    always @(negedge clk) begin
        if (reset) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (mem_read) rd_cnt++;
            if (mem_write) wr_cnt++;
            if (resp_valid) begin
                resp_cnt++;
                last_rdata = resp_rdata;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got rdata %h with empty scoreboard", resp_rdata);
                end else begin
                    e_m = q.pop_front();
                    chk("resp_error", 32'(resp_error), 32'(e_m.err));
                    chk("resp_rdata", resp_rdata, e_m.rdata);
                    chk("latency", 32'(cyc - e_m.acc), 32'(e_m.lat));
                    chk("mem_read_cycles", 32'(rd_cnt), 32'(e_m.rd));
                    chk("mem_write_cycles", 32'(wr_cnt), 32'(e_m.wr));
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        int          r, nres, bad;
        for (int i = 0; i < 1024; i++) setword(i, $urandom);
        setword(0, 32'h8077_F0A1);
        setword(1, 32'h1122_3344);
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {27'b0, busy, resp_valid, resp_error, mem_read, mem_write}, 0);
        chk("reset_rdata", resp_rdata, 0);
        chk("reset_addr", mem_address, 0);
        chk("reset_wdata", mem_write_data, 0);
        reset = 0;
        @(negedge clk);

        issue(0, 3'b000, 32'd1, 0, 1); drain(); chk("lb_addr1", last_rdata, 32'hFFFF_FFF0);
        issue(0, 3'b100, 32'd3, 0, 1); drain(); chk("lbu_addr3", last_rdata, 32'h0000_0080);
        issue(1, 3'b001, 32'd6, 32'hAAAA_BEEF, 1); drain(); chk("sh_merge", dmem[1], 32'hBEEF_3344);
        issue(0, 3'b101, 32'd6, 0, 1); drain(); chk("lhu_addr6", last_rdata, 32'h0000_BEEF);
        issue(1, 3'b010, 32'd8, 32'hDEAD_BEEF, 1); drain();
        issue(0, 3'b010, 32'd8, 0, 1); drain(); chk("lw_addr8", last_rdata, 32'hDEAD_BEEF);
        issue(0, 3'b010, 32'h6, 0, 1);
        issue(1, 3'b001, 32'h3, 32'h1234_5678, 1);
        issue(0, 3'b000, 32'h1000, 0, 1);
        issue(0, 3'b011, 32'h0, 0, 1);
        drain();

        // Reset during the write cycle of an SB must suppress the write and the response
        issue(1, 3'b000, 32'd4, 32'h0000_0055, 0);
        req_valid = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        #1 chk("abort_mem_write", 32'(mem_write), 0);
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_resp_valid", 32'(resp_valid), 0);
        reset = 0;
        @(negedge clk);
        chk("abort_mem1", dmem[1], 32'hBEEF_3344);

        // Back-to-back with req_valid held high
        nres = resp_cnt;
        issue(0, 3'b010, 32'd8, 0, 1);
        issue(1, 3'b000, 32'd9, 32'h0000_00C3, 1);
        issue(0, 3'b010, 32'd8, 0, 1);
        drain();
        chk("b2b_resp_count", 32'(resp_cnt - nres), 3);
        chk("b2b_last", last_rdata, 32'hDEAD_C3EF);

        for (int k = 0; k < 400; k++) begin
            f3 = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 19);
            a = r == 0 ? $urandom : r == 1 ? 32'd4096 : r == 2 ? 32'd4092 : 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) < 7) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            issue(1'($urandom_range(0, 1)), f3, a, $urandom, 1);
            if ($urandom_range(0, 3) != 0) begin
                req_valid = 0;
                req_write = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        drain();

        bad = 0;
        for (int i = 0; i < 1024; i++)
            for (int j = 0; j < 4; j++)
                if (dmem[i][8*j +: 8] !== refb[i*4+j]) bad++;
        chk("final_mem_bytes_wrong", 32'(bad), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
